// File: rtl/pipe_scoreboard_if.sv
// Decode-side bundle between the ID stage and the hazard/bypass scoreboard.
// The master modport is the decode stage and the slave modport is the scoreboard.
interface pipe_scoreboard_if #(
  parameter int NUM_STAGES = 3,
  parameter int REG_ADDR_W = 5,
  parameter int SEL_W      = $clog2(NUM_STAGES + 1)
);
  logic                  issue_valid_i;
  logic [REG_ADDR_W-1:0] rs1_i;
  logic [REG_ADDR_W-1:0] rs2_i;
  logic                  rs1_en_i;
  logic                  rs2_en_i;
  logic [REG_ADDR_W-1:0] rd_i;
  logic                  rd_en_i;
  logic                  is_load_i;
  logic                  is_mdu_i;
  logic                  mdu_fin_i;
  logic                  mem_wait_i;
  logic                  mispredict_i;
  logic [SEL_W-1:0]      src1_sel_o;
  logic [SEL_W-1:0]      src2_sel_o;
  logic                  stall_d_o;
  logic                  stall_e_o;
  logic                  flush_o;
  logic                  issue_fire_o;

  modport master (
    output issue_valid_i, rs1_i, rs2_i, rs1_en_i, rs2_en_i, rd_i, rd_en_i,
           is_load_i, is_mdu_i, mdu_fin_i, mem_wait_i, mispredict_i,
    input  src1_sel_o, src2_sel_o, stall_d_o, stall_e_o, flush_o, issue_fire_o
  );

  modport slave (
    input  issue_valid_i, rs1_i, rs2_i, rs1_en_i, rs2_en_i, rd_i, rd_en_i,
           is_load_i, is_mdu_i, mdu_fin_i, mem_wait_i, mispredict_i,
    output src1_sel_o, src2_sel_o, stall_d_o, stall_e_o, flush_o, issue_fire_o
  );
endinterface

// File: rtl/pipe_scoreboard.sv
// Shift-register scoreboard of in-flight producers (EXE..WB) giving operand bypass selects, stall and flush;
// outputs are combinational in the decode cycle, and slots hold while stall_e_o is set. SCOREBOARD_BYPASS_EN enables forwarding.
module pipe_scoreboard #(
  parameter int NUM_STAGES       = 3,
  parameter int REG_ADDR_W       = 5,
  parameter int LOAD_READY_STAGE = 1,
  parameter int SEL_W            = $clog2(NUM_STAGES + 1)
) (
  input logic              clk,
  input logic              reset,
  pipe_scoreboard_if.slave sb
);

`ifdef SCOREBOARD_BYPASS_EN
  localparam bit BYPASS_EN = 1'b1;
`else
  localparam bit BYPASS_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    KIND_ALU  = 2'd0,
    KIND_LOAD = 2'd1,
    KIND_MDU  = 2'd2
  } kind_t;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  wr;
    kind_t                 kind;
  } slot_t;

  typedef struct packed {
    logic             haz;
    logic [SEL_W-1:0] sel;
  } src_res_t;

  slot_t                 slots [NUM_STAGES];
  slot_t                 new_slot;
  logic [NUM_STAGES-1:0] slot_rdy;
  src_res_t              res1;
  src_res_t              res2;
  logic                  hazard;
  logic                  stall_e;
  logic                  flush;
  logic                  stall_d;
  logic                  fire;

  // Without bypass only the WB slot is usable, since it reads through the write-first regfile.
  always_comb begin
    slot_rdy = '0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      if (BYPASS_EN) begin
        case (slots[k].kind)
          KIND_LOAD: slot_rdy[k] = (k >= LOAD_READY_STAGE);
          KIND_MDU:  slot_rdy[k] = (k >= 1) || sb.mdu_fin_i;
          default:   slot_rdy[k] = 1'b1;
        endcase
      end else begin
        slot_rdy[k] = (k == NUM_STAGES - 1);
      end
    end
  end

  // Scan oldest to youngest so the youngest matching producer decides.
  function automatic src_res_t resolve(input logic en, input logic [REG_ADDR_W-1:0] src);
    src_res_t r;
    r = '0;
    if (en && (src != '0)) begin
      for (int k = NUM_STAGES - 1; k >= 0; k--) begin
        if (slots[k].valid && slots[k].wr && (slots[k].rd == src)) begin
          if (slot_rdy[k]) begin
            r.haz = 1'b0;
            r.sel = SEL_W'(k + 1);
          end else begin
            r.haz = 1'b1;
            r.sel = '0;
          end
        end
      end
    end
    return r;
  endfunction

  always_comb begin
    res1 = resolve(sb.rs1_en_i, sb.rs1_i);
    res2 = resolve(sb.rs2_en_i, sb.rs2_i);
  end

  assign hazard  = res1.haz | res2.haz;
  assign stall_e = sb.mem_wait_i |
                   (slots[0].valid && (slots[0].kind == KIND_MDU) && !sb.mdu_fin_i);
  assign flush   = sb.mispredict_i & ~stall_e;
  assign stall_d = stall_e | (sb.issue_valid_i & hazard & ~flush);
  assign fire    = sb.issue_valid_i & ~stall_d & ~flush & ~reset;

  assign sb.src1_sel_o   = BYPASS_EN ? res1.sel : '0;
  assign sb.src2_sel_o   = BYPASS_EN ? res2.sel : '0;
  assign sb.stall_e_o    = stall_e;
  assign sb.stall_d_o    = stall_d;
  assign sb.flush_o      = flush;
  assign sb.issue_fire_o = fire;

  always_comb begin
    new_slot       = '0;
    new_slot.valid = fire;
    new_slot.rd    = sb.rd_i;
    new_slot.wr    = sb.rd_en_i && (sb.rd_i != '0);
    if (sb.is_load_i)     new_slot.kind = KIND_LOAD;
    else if (sb.is_mdu_i) new_slot.kind = KIND_MDU;
    else                  new_slot.kind = KIND_ALU;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NUM_STAGES; k++) begin
        slots[k].valid <= 1'b0;
      end
    end else if (!stall_e) begin
      for (int k = NUM_STAGES - 1; k >= 1; k--) begin
        slots[k] <= slots[k-1];
      end
      slots[0] <= new_slot;
    end
  end

endmodule

// File: tb/tb_pipe_scoreboard.sv
// Directed bench for pipe_scoreboard: each step queues its expected outputs and checks them mid-cycle.
module tb_pipe_scoreboard;

`ifdef SCOREBOARD_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct packed {
    logic       iv;
    logic [4:0] rs1;
    logic       e1;
    logic [4:0] rs2;
    logic       e2;
    logic [4:0] rd;
    logic       rde;
    logic       ld;
    logic       mdu;
    logic       fin;
    logic       memw;
    logic       mis;
    logic       rst;
  } stim_t;

  typedef struct packed {
    logic [1:0] s1;
    logic [1:0] s2;
    logic       sd;
    logic       se;
    logic       fl;
    logic       fire;
  } exp_t;

  logic  clk;
  logic  reset;
  int    checks;
  int    errors;
  exp_t  exp_q [$];
  stim_t s;

  pipe_scoreboard_if #(.NUM_STAGES(3), .REG_ADDR_W(5)) sb ();

  pipe_scoreboard #(
    .NUM_STAGES(3),
    .REG_ADDR_W(5),
    .LOAD_READY_STAGE(1)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .sb   (sb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic stim_t op(input int rd, input int rs1, input int rs2);
    stim_t t;
    t     = '0;
    t.iv  = 1'b1;
    t.rd  = 5'(rd);
    t.rde = 1'b1;
    t.rs1 = 5'(rs1);
    t.e1  = 1'b1;
    t.rs2 = 5'(rs2);
    t.e2  = 1'b1;
    return t;
  endfunction

  function automatic stim_t idle();
    stim_t t;
    t = '0;
    return t;
  endfunction

  function automatic exp_t ex(input int s1, input int s2, input int sd, input int se,
                              input int fl, input int fire);
    exp_t e;
    e.s1   = 2'(s1);
    e.s2   = 2'(s2);
    e.sd   = 1'(sd);
    e.se   = 1'(se);
    e.fl   = 1'(fl);
    e.fire = 1'(fire);
    return e;
  endfunction

  task automatic drive(input stim_t t);
    reset            = t.rst;
    sb.issue_valid_i = t.iv;
    sb.rs1_i         = t.rs1;
    sb.rs1_en_i      = t.e1;
    sb.rs2_i         = t.rs2;
    sb.rs2_en_i      = t.e2;
    sb.rd_i          = t.rd;
    sb.rd_en_i       = t.rde;
    sb.is_load_i     = t.ld;
    sb.is_mdu_i      = t.mdu;
    sb.mdu_fin_i     = t.fin;
    sb.mem_wait_i    = t.memw;
    sb.mispredict_i  = t.mis;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Inputs change just after the rising edge; outputs are sampled on the falling edge.
  task automatic step(input stim_t t, input exp_t e);
    exp_t got;
    exp_q.push_back(e);
    drive(t);
    @(negedge clk);
    got = exp_q.pop_front();
    chk("src1_sel", 8'(sb.src1_sel_o), 8'(got.s1));
    chk("src2_sel", 8'(sb.src2_sel_o), 8'(got.s2));
    chk("stall_d", 8'(sb.stall_d_o), 8'(got.sd));
    chk("stall_e", 8'(sb.stall_e_o), 8'(got.se));
    chk("flush", 8'(sb.flush_o), 8'(got.fl));
    chk("issue_fire", 8'(sb.issue_fire_o), 8'(got.fire));
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) step(idle(), ex(0, 0, 0, 0, 0, 0));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    s = idle();
    s.rst = 1'b1;
    drive(s);
    @(posedge clk);
    #1;

    // Reset held: slots are empty and nothing may fire.
    s = op(4, 1, 2); s.rst = 1'b1;
    step(s, ex(0, 0, 0, 0, 0, 0));
    step(idle(), ex(0, 0, 0, 0, 0, 0));

    // ALU back-to-back.
    step(op(5, 1, 2), ex(0, 0, 0, 0, 0, 1));
    step(op(6, 5, 4), BYP ? ex(1, 0, 0, 0, 0, 1) : ex(0, 0, 1, 0, 0, 0));
    step(op(10, 5, 0), BYP ? ex(2, 0, 0, 0, 0, 1) : ex(0, 0, 1, 0, 0, 0));
    step(op(11, 5, 0), BYP ? ex(3, 0, 0, 0, 0, 1) : ex(0, 0, 0, 0, 0, 1));
    drain();

    // Load-use.
    s = op(7, 1, 0); s.ld = 1'b1;
    step(s, ex(0, 0, 0, 0, 0, 1));
    step(op(12, 7, 7), ex(0, 0, 1, 0, 0, 0));
    step(op(12, 7, 7), BYP ? ex(2, 2, 0, 0, 0, 1) : ex(0, 0, 1, 0, 0, 0));
    s = BYP ? idle() : op(12, 7, 7);
    step(s, BYP ? ex(0, 0, 0, 0, 0, 0) : ex(0, 0, 0, 0, 0, 1));
    drain();

    // Multi-cycle divide with a dependent waiting in decode.
    s = op(9, 1, 2); s.mdu = 1'b1;
    step(s, ex(0, 0, 0, 0, 0, 1));
    for (int i = 0; i < 4; i++) step(op(13, 9, 0), ex(0, 0, 1, 1, 0, 0));
    s = op(13, 9, 0); s.fin = 1'b1;
    step(s, BYP ? ex(1, 0, 0, 0, 0, 1) : ex(0, 0, 1, 0, 0, 0));
    s = BYP ? idle() : op(13, 9, 0);
    step(s, BYP ? ex(0, 0, 0, 0, 0, 0) : ex(0, 0, 1, 0, 0, 0));
    step(s, BYP ? ex(0, 0, 0, 0, 0, 0) : ex(0, 0, 0, 0, 0, 1));
    drain();

    // Youngest producer wins; x0 never forwards or stalls; mem_wait masks mispredict.
    step(op(3, 1, 0), ex(0, 0, 0, 0, 0, 1));
    step(op(15, 1, 0), ex(0, 0, 0, 0, 0, 1));
    step(op(3, 1, 0), ex(0, 0, 0, 0, 0, 1));
    step(op(16, 3, 0), BYP ? ex(1, 0, 0, 0, 0, 1) : ex(0, 0, 1, 0, 0, 0));
    step(op(0, 1, 0), ex(0, 0, 0, 0, 0, 1));
    step(op(17, 0, 0), ex(0, 0, 0, 0, 0, 1));
    s = op(18, 1, 0); s.memw = 1'b1; s.mis = 1'b1;
    step(s, ex(0, 0, 1, 1, 0, 0));
    drain();

    // Flush beats a load-use hazard and leaves a bubble in slot 0.
    s = op(7, 1, 0); s.ld = 1'b1;
    step(s, ex(0, 0, 0, 0, 0, 1));
    s = op(20, 7, 0); s.mis = 1'b1;
    step(s, ex(0, 0, 0, 0, 1, 0));
    step(op(24, 20, 0), ex(0, 0, 0, 0, 0, 1));
    drain();

    // Reset mid-stream discards every in-flight producer.
    step(op(21, 1, 0), ex(0, 0, 0, 0, 0, 1));
    step(op(22, 1, 0), ex(0, 0, 0, 0, 0, 1));
    step(op(23, 1, 0), ex(0, 0, 0, 0, 0, 1));
    s = idle(); s.rst = 1'b1;
    step(s, ex(0, 0, 0, 0, 0, 0));
    step(op(25, 21, 22), ex(0, 0, 0, 0, 0, 1));
    step(op(26, 23, 0), ex(0, 0, 0, 0, 0, 1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
